// File: rtl/cacheline_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory burst ports around the arbiter.
interface cacheline_arbiter_if #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    // Arbiter view.
    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // Caches plus physical memory view.
    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Serialises icache/dcache line fills and writebacks onto one burst memory port.
module cacheline_arbiter #(
    parameter int unsigned LINE_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter bit          FIXED_D_PRIO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    cacheline_arbiter_if.slave bus,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] wdata;
    } req_t;

    state_t state, state_nxt;
    req_t   lat, lat_nxt;
    logic   last_d, last_d_nxt;
    logic   pmem_read_q, pmem_write_q, busy_q;
    logic   pmem_read_nxt, pmem_write_nxt;
    logic   i_req_c, d_req_c, grant_d_c;
    logic   i_resp_c, d_resp_c;

    assign i_req_c = bus.i_pmem_read;
    assign d_req_c = bus.d_pmem_read | bus.d_pmem_write;

    // D wins when alone, under fixed priority, or on a tie when I was served last.
    assign grant_d_c = d_req_c & (~i_req_c | FIXED_D_PRIO | ~last_d);

    // Next-state, request latching and completion routing.
    always_comb begin
        state_nxt  = state;
        lat_nxt    = lat;
        last_d_nxt = last_d;
        i_resp_c   = 1'b0;
        d_resp_c   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d_c) begin
                    // Read+write together is illegal; it is served as a write.
                    lat_nxt    = '{write: bus.d_pmem_write, addr: bus.d_pmem_address,
                                   wdata: bus.d_pmem_wdata};
                    last_d_nxt = 1'b1;
                    state_nxt  = SERVE_D;
                end else if (i_req_c) begin
                    lat_nxt    = '{write: 1'b0, addr: bus.i_pmem_address, wdata: '0};
                    last_d_nxt = 1'b0;
                    state_nxt  = SERVE_I;
                end
            end
            SERVE_I: begin
                if (bus.pmem_resp) begin
                    i_resp_c  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            SERVE_D: begin
                if (bus.pmem_resp) begin
                    d_resp_c  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        pmem_read_nxt  = ((state_nxt == SERVE_I) || (state_nxt == SERVE_D)) && !lat_nxt.write;
        pmem_write_nxt = ((state_nxt == SERVE_I) || (state_nxt == SERVE_D)) &&  lat_nxt.write;
    end

    // State, latched request and registered memory strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat          <= '0;
            last_d       <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            lat          <= lat_nxt;
            last_d       <= last_d_nxt;
            pmem_read_q  <= pmem_read_nxt;
            pmem_write_q <= pmem_write_nxt;
            busy_q       <= (state_nxt != IDLE);
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = lat.addr;
    assign bus.pmem_wdata   = lat.wdata;
    assign bus.i_pmem_resp  = i_resp_c;
    assign bus.d_pmem_resp  = d_resp_c;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
    assign busy             = busy_q;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: one fixed-priority and one round-robin instance.
`timescale 1ns/1ps
module tb_cacheline_arbiter;
    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_read  [2];
    logic [AW-1:0] i_addr  [2];
    logic          d_read  [2];
    logic          d_write [2];
    logic [AW-1:0] d_addr  [2];
    logic [LW-1:0] d_wdata [2];
    logic [LW-1:0] m_rdata [2];
    logic          m_resp  [2];
    logic          o_pread [2];
    logic          o_pwrite[2];
    logic          o_iresp [2];
    logic          o_dresp [2];
    logic          o_busy  [2];
    logic [AW-1:0] o_paddr [2];
    logic [LW-1:0] o_pwdata[2];
    logic [LW-1:0] o_irdata[2];
    logic [LW-1:0] o_drdata[2];
    logic          busy0, busy1;

    int checks = 0;
    int errors = 0;
    bit m_last_d [2];   // model: 1 = D was granted last

    cacheline_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus0 ();
    cacheline_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus1 ();

    cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIXED_D_PRIO(1'b1)) dut_fix (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
    cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIXED_D_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

    assign bus0.i_pmem_read    = i_read[0];
    assign bus0.i_pmem_address = i_addr[0];
    assign bus0.d_pmem_read    = d_read[0];
    assign bus0.d_pmem_write   = d_write[0];
    assign bus0.d_pmem_address = d_addr[0];
    assign bus0.d_pmem_wdata   = d_wdata[0];
    assign bus0.pmem_rdata     = m_rdata[0];
    assign bus0.pmem_resp      = m_resp[0];
    assign o_pread[0]  = bus0.pmem_read;
    assign o_pwrite[0] = bus0.pmem_write;
    assign o_paddr[0]  = bus0.pmem_address;
    assign o_pwdata[0] = bus0.pmem_wdata;
    assign o_iresp[0]  = bus0.i_pmem_resp;
    assign o_dresp[0]  = bus0.d_pmem_resp;
    assign o_irdata[0] = bus0.i_pmem_rdata;
    assign o_drdata[0] = bus0.d_pmem_rdata;
    assign o_busy[0]   = busy0;

    assign bus1.i_pmem_read    = i_read[1];
    assign bus1.i_pmem_address = i_addr[1];
    assign bus1.d_pmem_read    = d_read[1];
    assign bus1.d_pmem_write   = d_write[1];
    assign bus1.d_pmem_address = d_addr[1];
    assign bus1.d_pmem_wdata   = d_wdata[1];
    assign bus1.pmem_rdata     = m_rdata[1];
    assign bus1.pmem_resp      = m_resp[1];
    assign o_pread[1]  = bus1.pmem_read;
    assign o_pwrite[1] = bus1.pmem_write;
    assign o_paddr[1]  = bus1.pmem_address;
    assign o_pwdata[1] = bus1.pmem_wdata;
    assign o_iresp[1]  = bus1.i_pmem_resp;
    assign o_dresp[1]  = bus1.d_pmem_resp;
    assign o_irdata[1] = bus1.i_pmem_rdata;
    assign o_drdata[1] = bus1.d_pmem_rdata;
    assign o_busy[1]   = busy1;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom() & 32'hFFFF_FFE0);
    endfunction

    // Arbitration rule: instance 0 always favours D, instance 1 alternates on ties.
    function automatic bit model_pick_d(input int k, input bit ir, input bit dr);
        if (ir && dr) return (k == 0) ? 1'b1 : !m_last_d[k];
        return dr;
    endfunction

    task automatic clear_inputs(input int k);
        i_read[k] = 1'b0; i_addr[k] = '0; d_read[k] = 1'b0; d_write[k] = 1'b0;
        d_addr[k] = '0; d_wdata[k] = '0; m_rdata[k] = '0; m_resp[k] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_read[k] = 1'b1; i_addr[k] = '1; d_write[k] = 1'b1; d_addr[k] = '1;
            d_wdata[k] = '1; m_resp[k] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy k=%0d got %b want 0", k, o_busy[k]); end
            checks++; if (o_pread[k] !== 1'b0 || o_pwrite[k] !== 1'b0) begin errors++; $display("FAIL reset_rw k=%0d got r%b w%b want 0", k, o_pread[k], o_pwrite[k]); end
            checks++; if (o_paddr[k] !== '0 || o_pwdata[k] !== '0) begin errors++; $display("FAIL reset_addr k=%0d got %h want 0", k, o_paddr[k]); end
            checks++; if (o_iresp[k] !== 1'b0 || o_dresp[k] !== 1'b0) begin errors++; $display("FAIL reset_resp k=%0d got i%b d%b want 0", k, o_iresp[k], o_dresp[k]); end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin clear_inputs(k); m_last_d[k] = 1'b0; end
    endtask

    task automatic test_single_read(input int k);
        logic [LW-1:0] rd;
        rd = rand_line();
        @(negedge clk); i_read[k] = 1'b1; i_addr[k] = AW'(32'h60); #1;
        checks++; if (o_pread[k] !== 1'b0) begin errors++; $display("FAIL single_c0 k=%0d got %b want 0", k, o_pread[k]); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            checks++; if (o_pread[k] !== 1'b1 || o_pwrite[k] !== 1'b0 || o_paddr[k] !== AW'(32'h60))
                begin errors++; $display("FAIL single_serve k=%0d c=%0d got r%b w%b a%h want r1 w0 a60", k, c, o_pread[k], o_pwrite[k], o_paddr[k]); end
        end
        @(negedge clk); m_resp[k] = 1'b1; m_rdata[k] = rd; #1;
        checks++; if (o_iresp[k] !== 1'b1 || o_dresp[k] !== 1'b0) begin errors++; $display("FAIL single_resp k=%0d got i%b d%b want i1 d0", k, o_iresp[k], o_dresp[k]); end
        checks++; if (o_irdata[k] !== rd || o_drdata[k] !== rd) begin errors++; $display("FAIL single_rdata k=%0d got %h want %h", k, o_irdata[k], rd); end
        @(negedge clk); m_resp[k] = 1'b0; i_read[k] = 1'b0; #1;
        checks++; if (o_pread[k] !== 1'b0 || o_iresp[k] !== 1'b0 || o_busy[k] !== 1'b1) begin errors++; $display("FAIL single_release k=%0d got r%b i%b busy%b want r0 i0 busy1", k, o_pread[k], o_iresp[k], o_busy[k]); end
        @(negedge clk); #1;
        checks++; if (o_busy[k] !== 1'b0) begin errors++; $display("FAIL single_idle k=%0d got %b want 0", k, o_busy[k]); end
        m_last_d[k] = 1'b0;
    endtask

    task automatic test_fixed_prio(input int k);
        logic [LW-1:0] wd, rd;
        int n;
        wd = {32{8'hA5}};
        rd = rand_line();
        n  = 2 + int'($urandom_range(0, 3));
        @(negedge clk);
        i_read[k] = 1'b1; i_addr[k] = AW'(32'h100);
        d_write[k] = 1'b1; d_addr[k] = AW'(32'h200); d_wdata[k] = wd;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk); #1;
            checks++; if (o_pwrite[k] !== 1'b1 || o_pread[k] !== 1'b0 || o_paddr[k] !== AW'(32'h200) || o_pwdata[k] !== wd)
                begin errors++; $display("FAIL prio_first k=%0d got r%b w%b a%h want r0 w1 a200", k, o_pread[k], o_pwrite[k], o_paddr[k]); end
        end
        @(negedge clk); m_resp[k] = 1'b1; m_rdata[k] = rd; #1;
        checks++; if (o_dresp[k] !== 1'b1 || o_iresp[k] !== 1'b0 || o_drdata[k] !== rd) begin errors++; $display("FAIL prio_dresp k=%0d got d%b i%b want d1 i0", k, o_dresp[k], o_iresp[k]); end
        @(negedge clk); m_resp[k] = 1'b0; d_write[k] = 1'b0; #1;
        checks++; if (o_pread[k] !== 1'b0 || o_pwrite[k] !== 1'b0 || o_iresp[k] !== 1'b0 || o_dresp[k] !== 1'b0)
            begin errors++; $display("FAIL prio_release k=%0d got r%b w%b want 0", k, o_pread[k], o_pwrite[k]); end
        @(negedge clk); #1;
        checks++; if (o_pread[k] !== 1'b0 || o_busy[k] !== 1'b0) begin errors++; $display("FAIL prio_idle k=%0d got r%b busy%b want 0", k, o_pread[k], o_busy[k]); end
        @(negedge clk); #1;
        checks++; if (o_pread[k] !== 1'b1 || o_pwrite[k] !== 1'b0 || o_paddr[k] !== AW'(32'h100))
            begin errors++; $display("FAIL prio_second k=%0d got r%b w%b a%h want r1 w0 a100", k, o_pread[k], o_pwrite[k], o_paddr[k]); end
        @(negedge clk); m_resp[k] = 1'b1; #1;
        checks++; if (o_iresp[k] !== 1'b1 || o_dresp[k] !== 1'b0) begin errors++; $display("FAIL prio_iresp k=%0d got i%b d%b want i1 d0", k, o_iresp[k], o_dresp[k]); end
        @(negedge clk); m_resp[k] = 1'b0; i_read[k] = 1'b0; #1;
        @(negedge clk); #1;
        m_last_d[k] = 1'b0;
    endtask

    task automatic test_round_robin(input int k);
        bit exp_d;
        @(negedge clk);
        i_read[k] = 1'b1; d_read[k] = 1'b1; i_addr[k] = rand_addr(); d_addr[k] = rand_addr(); #1;
        for (int t = 0; t < 3; t++) begin
            exp_d = model_pick_d(k, 1'b1, 1'b1);
            m_last_d[k] = exp_d;
            @(negedge clk); #1;
            checks++; if (o_pread[k] !== 1'b1 || o_paddr[k] !== (exp_d ? d_addr[k] : i_addr[k]))
                begin errors++; $display("FAIL rr_grant k=%0d t=%0d got r%b a%h want r1 a%h", k, t, o_pread[k], o_paddr[k], exp_d ? d_addr[k] : i_addr[k]); end
            @(negedge clk); m_resp[k] = 1'b1; #1;
            checks++; if (o_dresp[k] !== exp_d || o_iresp[k] !== !exp_d)
                begin errors++; $display("FAIL rr_resp k=%0d t=%0d got d%b i%b want d%b", k, t, o_dresp[k], o_iresp[k], exp_d); end
            @(negedge clk); m_resp[k] = 1'b0; i_addr[k] = rand_addr(); d_addr[k] = rand_addr(); #1;
            checks++; if (o_pread[k] !== 1'b0) begin errors++; $display("FAIL rr_release k=%0d t=%0d got %b want 0", k, t, o_pread[k]); end
            @(negedge clk); #1;
        end
        clear_inputs(k);
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    task automatic test_addr_stable(input int k);
        int n;
        n = 3 + int'($urandom_range(0, 3));
        @(negedge clk); d_read[k] = 1'b1; d_addr[k] = AW'(32'h300); #1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) d_addr[k] = AW'(32'h340);
            if (c == 2) d_read[k] = 1'b0;
            #1;
            checks++; if (o_pread[k] !== 1'b1 || o_paddr[k] !== AW'(32'h300))
                begin errors++; $display("FAIL stable_addr k=%0d c=%0d got r%b a%h want r1 a300", k, c, o_pread[k], o_paddr[k]); end
        end
        @(negedge clk); m_resp[k] = 1'b1; #1;
        checks++; if (o_dresp[k] !== 1'b1 || o_paddr[k] !== AW'(32'h300)) begin errors++; $display("FAIL stable_resp k=%0d got d%b a%h want d1 a300", k, o_dresp[k], o_paddr[k]); end
        @(negedge clk); m_resp[k] = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (o_busy[k] !== 1'b0) begin errors++; $display("FAIL stable_idle k=%0d got %b want 0", k, o_busy[k]); end
        clear_inputs(k);
        m_last_d[k] = 1'b1;
    endtask

    task automatic test_illegal_spurious(input int k);
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); m_resp[k] = 1'b1; m_rdata[k] = rand_line(); #1;
            checks++; if (o_iresp[k] !== 1'b0 || o_dresp[k] !== 1'b0 || o_busy[k] !== 1'b0)
                begin errors++; $display("FAIL spur_idle k=%0d c=%0d got i%b d%b busy%b want 0", k, c, o_iresp[k], o_dresp[k], o_busy[k]); end
            checks++; if (o_irdata[k] !== m_rdata[k] || o_drdata[k] !== m_rdata[k]) begin errors++; $display("FAIL spur_bcast k=%0d got %h want %h", k, o_irdata[k], m_rdata[k]); end
        end
        a = rand_addr(); wd = rand_line();
        @(negedge clk); m_resp[k] = 1'b0; d_read[k] = 1'b1; d_write[k] = 1'b1; d_addr[k] = a; d_wdata[k] = wd; #1;
        @(negedge clk); #1;
        checks++; if (o_pwrite[k] !== 1'b1 || o_pread[k] !== 1'b0 || o_paddr[k] !== a || o_pwdata[k] !== wd)
            begin errors++; $display("FAIL illegal_rw k=%0d got r%b w%b a%h want r0 w1 a%h", k, o_pread[k], o_pwrite[k], o_paddr[k], a); end
        @(negedge clk); m_resp[k] = 1'b1; #1;
        checks++; if (o_dresp[k] !== 1'b1 || o_iresp[k] !== 1'b0) begin errors++; $display("FAIL illegal_resp k=%0d got d%b i%b want d1 i0", k, o_dresp[k], o_iresp[k]); end
        @(negedge clk); d_read[k] = 1'b0; d_write[k] = 1'b0; #1;
        checks++; if (o_dresp[k] !== 1'b0 || o_iresp[k] !== 1'b0 || o_pwrite[k] !== 1'b0 || o_busy[k] !== 1'b1)
            begin errors++; $display("FAIL spur_release k=%0d got d%b i%b w%b busy%b want 0 0 0 1", k, o_dresp[k], o_iresp[k], o_pwrite[k], o_busy[k]); end
        @(negedge clk); m_resp[k] = 1'b0; #1;
        checks++; if (o_busy[k] !== 1'b0) begin errors++; $display("FAIL spur_after k=%0d got %b want 0", k, o_busy[k]); end
        m_last_d[k] = 1'b1;
    endtask

    task automatic test_reset_mid(input int k);
        logic [AW-1:0] a;
        int n;
        a = rand_addr();
        n = 1 + int'($urandom_range(0, 3));
        @(negedge clk); i_read[k] = 1'b1; i_addr[k] = a; #1;
        @(negedge clk); #1;
        checks++; if (o_pread[k] !== 1'b1) begin errors++; $display("FAIL rstmid_pre k=%0d got %b want 1", k, o_pread[k]); end
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; m_resp[k] = 1'b1; #1;
        m_last_d[0] = 1'b0; m_last_d[1] = 1'b0;
        checks++; if (o_busy[k] !== 1'b0 || o_pread[k] !== 1'b0 || o_iresp[k] !== 1'b0 || o_paddr[k] !== '0)
            begin errors++; $display("FAIL rstmid_after k=%0d got busy%b r%b i%b a%h want 0", k, o_busy[k], o_pread[k], o_iresp[k], o_paddr[k]); end
        for (int c = 0; c < n; c++) begin
            @(negedge clk); m_resp[k] = 1'b0; #1;
            checks++; if (o_pread[k] !== 1'b1 || o_paddr[k] !== a) begin errors++; $display("FAIL rstmid_reissue k=%0d got r%b a%h want r1 a%h", k, o_pread[k], o_paddr[k], a); end
        end
        @(negedge clk); m_resp[k] = 1'b1; #1;
        checks++; if (o_iresp[k] !== 1'b1 || o_dresp[k] !== 1'b0) begin errors++; $display("FAIL rstmid_resp k=%0d got i%b d%b want i1 d0", k, o_iresp[k], o_dresp[k]); end
        @(negedge clk); m_resp[k] = 1'b0; i_read[k] = 1'b0; #1;
        @(negedge clk); #1;
        clear_inputs(k);
    endtask

    task automatic test_random(input int k);
        bit ip, dp, exp_d, exp_w;
        int op, n;
        logic [AW-1:0] ia, da, exp_a;
        logic [LW-1:0] dwd, rd;
        ip = 1'b0; dp = 1'b0; op = 0; ia = '0; da = '0; dwd = '0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (!ip && $urandom_range(0, 9) < 6) begin ip = 1'b1; ia = rand_addr(); end
            if (!dp && $urandom_range(0, 9) < 6) begin dp = 1'b1; da = rand_addr(); dwd = rand_line(); op = int'($urandom_range(0, 4)); end
            i_read[k] = ip; i_addr[k] = ia;
            d_read[k] = dp && (op < 2 || op == 4); d_write[k] = dp && (op >= 2);
            d_addr[k] = da; d_wdata[k] = dwd;
            m_resp[k] = ($urandom_range(0, 3) == 0);
            #1;
            checks++; if (o_busy[k] !== 1'b0 || o_iresp[k] !== 1'b0 || o_dresp[k] !== 1'b0)
                begin errors++; $display("FAIL rnd_idle k=%0d t=%0d got busy%b i%b d%b want 0", k, t, o_busy[k], o_iresp[k], o_dresp[k]); end
            if (!ip && !dp) continue;
            exp_d = model_pick_d(k, ip, dp);
            exp_w = exp_d && (op >= 2);
            exp_a = exp_d ? da : ia;
            m_last_d[k] = exp_d;
            n = 1 + int'($urandom_range(0, 3));
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                m_resp[k] = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    if (exp_d) d_addr[k] = rand_addr(); else i_addr[k] = rand_addr();
                end
                #1;
                checks++; if (o_pread[k] !== !exp_w || o_pwrite[k] !== exp_w || o_paddr[k] !== exp_a || (exp_w && o_pwdata[k] !== dwd))
                    begin errors++; $display("FAIL rnd_serve k=%0d t=%0d got r%b w%b a%h want r%b w%b a%h", k, t, o_pread[k], o_pwrite[k], o_paddr[k], !exp_w, exp_w, exp_a); end
                checks++; if (o_iresp[k] !== 1'b0 || o_dresp[k] !== 1'b0) begin errors++; $display("FAIL rnd_early k=%0d t=%0d got i%b d%b want 0", k, t, o_iresp[k], o_dresp[k]); end
            end
            rd = rand_line();
            @(negedge clk); m_resp[k] = 1'b1; m_rdata[k] = rd; #1;
            checks++; if (o_dresp[k] !== exp_d || o_iresp[k] !== !exp_d || o_irdata[k] !== rd || o_drdata[k] !== rd)
                begin errors++; $display("FAIL rnd_resp k=%0d t=%0d got d%b i%b want d%b i%b", k, t, o_dresp[k], o_iresp[k], exp_d, !exp_d); end
            @(negedge clk);
            m_resp[k] = ($urandom_range(0, 1) == 1);
            if (exp_d) begin dp = 1'b0; d_read[k] = 1'b0; d_write[k] = 1'b0; end
            else begin ip = 1'b0; i_read[k] = 1'b0; end
            #1;
            checks++; if (o_pread[k] !== 1'b0 || o_pwrite[k] !== 1'b0 || o_iresp[k] !== 1'b0 || o_dresp[k] !== 1'b0 || o_busy[k] !== 1'b1)
                begin errors++; $display("FAIL rnd_release k=%0d t=%0d got r%b w%b i%b d%b busy%b", k, t, o_pread[k], o_pwrite[k], o_iresp[k], o_dresp[k], o_busy[k]); end
        end
        @(negedge clk); clear_inputs(k); #1;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin clear_inputs(k); m_last_d[k] = 1'b0; end
        test_reset();
        for (int k = 0; k < 2; k++) test_single_read(k);
        for (int k = 0; k < 2; k++) test_fixed_prio(k);
        for (int k = 0; k < 2; k++) test_round_robin(k);
        for (int k = 0; k < 2; k++) test_addr_stable(k);
        for (int k = 0; k < 2; k++) test_illegal_spurious(k);
        for (int k = 0; k < 2; k++) test_reset_mid(k);
        for (int k = 0; k < 2; k++) test_random(k);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
